// File: rtl/core_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer_if
// Purpose  : Handshake, fetch and branch-target-LUT bundle between the
//            top level / datapath (master) and the core sequencer (slave).
// Revision : 1.0  initial release
// ============================================================================
interface core_sequencer_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9,
  parameter int IDX_W   = 5,
  parameter int CNT_W   = 16
);
  // Run control and fetch stream
  logic               start;
  logic [INSTR_W-1:0] instr;
  logic               stall;
  logic               branch_taken;
  logic [IDX_W-1:0]   branch_idx;
  // Branch-target LUT write port
  logic               lut_we;
  logic [IDX_W-1:0]   lut_waddr;
  logic [PC_W-1:0]    lut_wdata;
  // Sequencer status
  logic [PC_W-1:0]    pc;
  logic               fetch_valid;
  logic               busy;
  logic               done;
  logic [1:0]         halt_code;
  logic [CNT_W-1:0]   cycle_count;
  logic [CNT_W-1:0]   retire_count;

  modport master (
    output start, instr, stall, branch_taken, branch_idx,
    output lut_we, lut_waddr, lut_wdata,
    input  pc, fetch_valid, busy, done, halt_code, cycle_count, retire_count
  );

  modport slave (
    input  start, instr, stall, branch_taken, branch_idx,
    input  lut_we, lut_waddr, lut_wdata,
    output pc, fetch_valid, busy, done, halt_code, cycle_count, retire_count
  );
endinterface
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer
// Purpose  : Fetch/run sequencer for the 9-bit core. Owns the PC, a writable
//            branch-target LUT, the start/done handshake and halt detection
//            (zero-instruction run, end of program space, cycle timeout).
// Revision : 1.0  initial release
// ============================================================================
module core_sequencer #(
  parameter int PC_W       = 8,
  parameter int INSTR_W    = 9,
  parameter int LUT_DEPTH  = 32,
  parameter int HALT_ZEROS = 1,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 4096,
  parameter int START_PC   = 0
) (
  input wire              clk,
  input wire              reset,
  core_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(LUT_DEPTH);
  // Zero-run counter must reach HALT_ZEROS on the halting retire
  localparam int ZW    = $clog2(HALT_ZEROS + 1);

  localparam logic [CNT_W-1:0] c_cyc_last  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [PC_W-1:0]  c_start_pc  = PC_W'(START_PC);
  localparam logic [ZW-1:0]    c_zero_last = ZW'(HALT_ZEROS - 1);
  localparam logic [1:0]       c_hc_none   = 2'b00;
  localparam logic [1:0]       c_hc_zero   = 2'b01;
  localparam logic [1:0]       c_hc_end    = 2'b10;
  localparam logic [1:0]       c_hc_tmo    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [1:0]       halt_code_q, halt_code_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [ZW-1:0]    zrun_q, zrun_d;
  logic [PC_W-1:0]  lut_q [LUT_DEPTH];
  logic [PC_W-1:0]  lut_d [LUT_DEPTH];

  logic             retire;
  logic             instr_zero;
  logic             halt_zero;
  logic             halt_end;
  logic             halt_tmo;
  logic [IDX_W-1:0] rd_idx;
  logic [PC_W-1:0]  branch_target;

  // Branch target read is combinational; a same-cycle write shows up next cycle
  assign rd_idx        = bus.branch_idx;
  assign branch_target = lut_q[rd_idx];

  assign retire     = (state_q == ST_RUN) && !bus.stall;
  assign instr_zero = (bus.instr == '0);
  assign halt_zero  = retire && instr_zero && (zrun_q == c_zero_last);
  assign halt_end   = retire && (pc_q == '1) && !bus.branch_taken;
  assign halt_tmo   = (state_q == ST_RUN) && (cycle_q == c_cyc_last);

  // LUT write port, honoured in every state
  always_comb begin
    lut_d = lut_q;
    if (bus.lut_we) begin
      lut_d[bus.lut_waddr] = bus.lut_wdata;
    end
  end

  // LUT storage, cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      lut_q <= lut_d;
    end
  end

  // Next-state, PC, counter and halt-code computation
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    halt_code_d = halt_code_q;
    cycle_d     = cycle_q;
    retire_d    = retire_q;
    zrun_d      = zrun_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d     = ST_RUN;
          pc_d        = c_start_pc;
          halt_code_d = c_hc_none;
          cycle_d     = '0;
          retire_d    = '0;
          zrun_d      = '0;
        end
      end
      ST_RUN: begin
        cycle_d = cycle_q + CNT_W'(1);
        if (retire) begin
          retire_d = (retire_q == '1) ? retire_q : retire_q + CNT_W'(1);
          zrun_d   = instr_zero ? zrun_q + ZW'(1) : '0;
          pc_d     = bus.branch_taken ? branch_target : pc_q + PC_W'(1);
        end
        // On halt the PC keeps pointing at the halting instruction
        if (halt_zero || halt_end || halt_tmo) begin
          state_d = ST_DONE;
          pc_d    = pc_q;
          if (halt_zero) begin
            halt_code_d = c_hc_zero;
          end else if (halt_end) begin
            halt_code_d = c_hc_end;
          end else begin
            halt_code_d = c_hc_tmo;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      halt_code_q <= c_hc_none;
      cycle_q     <= '0;
      retire_q    <= '0;
      zrun_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      halt_code_q <= halt_code_d;
      cycle_q     <= cycle_d;
      retire_q    <= retire_d;
      zrun_q      <= zrun_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.fetch_valid  = retire;
  assign bus.busy         = (state_q == ST_RUN);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.halt_code    = halt_code_q;
  assign bus.cycle_count  = cycle_q;
  assign bus.retire_count = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_sequencer
// Purpose  : Self-checking bench for core_sequencer. Two instances share one
//            stimulus stream (A: HALT_ZEROS=3, MAX_CYCLES=600; B: HALT_ZEROS=1,
//            MAX_CYCLES=20) and are compared every cycle to a run-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_core_sequencer;

  localparam int NZ = 9'h1AB;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stall, bt, lut_we;
  logic [8:0] instr;
  logic [4:0] bidx, waddr;
  logic [7:0] wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_sequencer_if #(.PC_W(8), .INSTR_W(9), .IDX_W(5), .CNT_W(16)) bus_a ();
  core_sequencer_if #(.PC_W(8), .INSTR_W(9), .IDX_W(5), .CNT_W(16)) bus_b ();

  assign bus_a.start = start;        assign bus_b.start = start;
  assign bus_a.instr = instr;        assign bus_b.instr = instr;
  assign bus_a.stall = stall;        assign bus_b.stall = stall;
  assign bus_a.branch_taken = bt;    assign bus_b.branch_taken = bt;
  assign bus_a.branch_idx = bidx;    assign bus_b.branch_idx = bidx;
  assign bus_a.lut_we = lut_we;      assign bus_b.lut_we = lut_we;
  assign bus_a.lut_waddr = waddr;    assign bus_b.lut_waddr = waddr;
  assign bus_a.lut_wdata = wdata;    assign bus_b.lut_wdata = wdata;

  core_sequencer #(.HALT_ZEROS(3), .MAX_CYCLES(600)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  core_sequencer #(.HALT_ZEROS(1), .MAX_CYCLES(20)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  // ---------------- behavioural model (per instance) ----------------
  int hz [2] = '{3, 1};
  int mc [2] = '{600, 20};
  int m_busy [2], m_done [2], m_pc [2], m_hc [2], m_cyc [2], m_ret [2], m_z [2];
  int m_lut [32];

  always @(posedge clk or posedge reset) begin : model
    int code;
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        m_busy[m] = 0; m_done[m] = 0; m_pc[m] = 0; m_hc[m] = 0;
        m_cyc[m] = 0; m_ret[m] = 0; m_z[m] = 0;
      end
      for (int i = 0; i < 32; i++) m_lut[i] = 0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (m_busy[m] == 0) begin
          if (start) begin
            m_busy[m] = 1; m_done[m] = 0; m_pc[m] = 0; m_hc[m] = 0;
            m_cyc[m] = 0; m_ret[m] = 0; m_z[m] = 0;
          end
        end else begin
          code = 0;
          if (!stall && instr == 0 && m_z[m] + 1 >= hz[m]) code = 1;
          else if (!stall && m_pc[m] == 255 && !bt)       code = 2;
          else if (m_cyc[m] + 1 == mc[m])                 code = 3;
          m_cyc[m] = (m_cyc[m] + 1) % 65536;
          if (!stall) begin
            m_ret[m] = (m_ret[m] == 65535) ? 65535 : m_ret[m] + 1;
            m_z[m]   = (instr == 0) ? m_z[m] + 1 : 0;
          end
          if (code != 0) begin
            m_busy[m] = 0; m_done[m] = 1; m_hc[m] = code;
          end else if (!stall) begin
            m_pc[m] = bt ? m_lut[bidx] : (m_pc[m] + 1) % 256;
          end
        end
      end
      if (lut_we) m_lut[waddr] = wdata;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input int m, input int pc, input int busy,
                         input int done, input int fv, input int hc, input int cyc,
                         input int ret);
    chk({tag, ".pc"},     pc,   m_pc[m]);
    chk({tag, ".busy"},   busy, m_busy[m]);
    chk({tag, ".done"},   done, m_done[m]);
    chk({tag, ".fv"},     fv,   (m_busy[m] != 0 && stall == 1'b0) ? 1 : 0);
    chk({tag, ".halt"},   hc,   m_hc[m]);
    chk({tag, ".cycles"}, cyc,  m_cyc[m]);
    chk({tag, ".retire"}, ret,  m_ret[m]);
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk_dut("a", 0, bus_a.pc, bus_a.busy, bus_a.done, bus_a.fetch_valid,
            bus_a.halt_code, bus_a.cycle_count, bus_a.retire_count);
    chk_dut("b", 1, bus_b.pc, bus_b.busy, bus_b.done, bus_b.fetch_valid,
            bus_b.halt_code, bus_b.cycle_count, bus_b.retire_count);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    start = 0; stall = 0; bt = 0; lut_we = 0; instr = NZ; bidx = 0; waddr = 0; wdata = 0;
  endtask

  initial begin : stim
    int seq [5] = '{0, 1, 2, 16, 17};
    int n;
    reset = 1'b1;
    idle_in();
    repeat (3) tick();
    chk("rst.pc", bus_a.pc, 0);
    chk("rst.busy", bus_a.busy, 0);
    chk("rst.done", bus_a.done, 0);
    chk("rst.cycles", bus_a.cycle_count, 0);
    reset = 1'b0;

    // Branch through LUT[3]=0x10
    lut_we = 1; waddr = 3; wdata = 8'h10;
    tick();
    lut_we = 0; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("branch.pc%0d", i), bus_a.pc, seq[i]);
      bt = (m_pc[0] == 2); bidx = 3;
      tick();
    end
    bt = 0;

    // Stall for four cycles at pc 0x12
    stall = 1;
    repeat (4) tick();
    chk("stall.pc", bus_a.pc, 8'h12);
    chk("stall.cycles", bus_a.cycle_count, 9);
    chk("stall.retire", bus_a.retire_count, 5);
    chk("stall.fv", bus_a.fetch_valid, 0);
    stall = 0;

    // Start while running is ignored
    start = 1;
    tick();
    start = 0;
    chk("startrun.pc", bus_a.pc, 8'h13);
    chk("startrun.cycles", bus_a.cycle_count, 10);
    chk("startrun.busy", bus_a.busy, 1);

    // Reset mid-run
    reset = 1;
    #1;
    chk("midrst.pc", bus_a.pc, 0);
    chk("midrst.busy", bus_a.busy, 0);
    chk("midrst.done", bus_a.done, 0);
    chk("midrst.retire", bus_a.retire_count, 0);
    chk("midrst.b.cycles", bus_b.cycle_count, 0);
    tick();
    reset = 0;

    // Zero-run halt: zeros at 5,6 then 8,9,10
    start = 1;
    tick();
    start = 0;
    n = 0;
    while (!m_done[0] && n < 40) begin
      instr = (m_pc[0] inside {5, 6, 8, 9, 10}) ? 9'd0 : 9'(NZ);
      tick();
      n++;
    end
    instr = NZ;
    chk("zero.done", bus_a.done, 1);
    chk("zero.halt", bus_a.halt_code, 1);
    chk("zero.pc", bus_a.pc, 10);
    chk("zero.retire", bus_a.retire_count, 11);
    chk("zero.b.pc", bus_b.pc, 5);
    chk("zero.b.halt", bus_b.halt_code, 1);
    chk("zero.b.retire", bus_b.retire_count, 6);

    // Restart from DONE, then loop at pc 1 until timeouts
    lut_we = 1; waddr = 5; wdata = 8'd1; start = 1;
    tick();
    lut_we = 0; start = 0;
    chk("restart.pc", bus_a.pc, 0);
    chk("restart.cycles", bus_a.cycle_count, 0);
    chk("restart.halt", bus_a.halt_code, 0);
    chk("restart.busy", bus_a.busy, 1);
    n = 0;
    while (!m_done[1] && n < 40) begin
      bt = (m_pc[0] == 1); bidx = 5;
      tick();
      n++;
    end
    chk("tmo.b.done", bus_b.done, 1);
    chk("tmo.b.halt", bus_b.halt_code, 3);
    chk("tmo.b.cycles", bus_b.cycle_count, 20);
    chk("tmo.b.pc", bus_b.pc, 1);
    n = 0;
    while (!m_done[0] && n < 700) begin
      bt = (m_pc[0] == 1); bidx = 5;
      tick();
      n++;
    end
    bt = 0;
    chk("tmo.a.halt", bus_a.halt_code, 3);
    chk("tmo.a.cycles", bus_a.cycle_count, 600);

    // Straight run to end of program space
    start = 1;
    tick();
    start = 0;
    n = 0;
    while (!m_done[0] && n < 300) begin
      tick();
      n++;
    end
    chk("end.halt", bus_a.halt_code, 2);
    chk("end.pc", bus_a.pc, 255);
    chk("end.retire", bus_a.retire_count, 256);

    // Branch at 0xFF wraps; same-cycle LUT write returns old value
    start = 1;
    tick();
    start = 0;
    n = 0;
    while (m_pc[0] != 255 && n < 300) begin
      tick();
      n++;
    end
    chk("wrap.at_end", bus_a.pc, 255);
    bt = 1; bidx = 0; lut_we = 1; waddr = 0; wdata = 8'h33;
    tick();
    lut_we = 0;
    chk("wrap.pc", bus_a.pc, 0);
    chk("wrap.busy", bus_a.busy, 1);
    tick();
    bt = 0;
    chk("wrap.newlut", bus_a.pc, 8'h33);

    // Randomised phase
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 7) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      bt     = ($urandom_range(0, 3) == 0);
      bidx   = 5'($urandom_range(0, 31));
      lut_we = ($urandom_range(0, 3) == 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = 8'($urandom_range(0, 255));
      instr  = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      if ($urandom_range(0, 499) == 0) begin
        reset = 1;
        tick();
        reset = 0;
      end else begin
        tick();
      end
    end
    idle_in();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
